// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-master Wishbone arbiter for the shared system-RAM port
//
// Purpose: shares the single RAM port between the CPU (master 0) and the
// read-only video fetch master (master 1). Video has priority. A burst limit
// gives the CPU one access in every BURST_MAX+1 grants under contention.
// Bus signals are forwarded combinationally from the owning master.
//
// Ports:
//   clk_i, res_i           clock, asynchronous active-high reset
//   m0_*                   CPU Wishbone master port (read/write)
//   m1_*                   video Wishbone master port (read only)
//   s_*                    RAM-side Wishbone port
//   gnt_o                  one-hot owner: bit 0 CPU, bit 1 video, 00 idle

module ram_arbiter #(
  parameter int BURST_MAX = 4
) (
  input  logic        clk_i,
  input  logic        res_i,
  input  logic [15:1] m0_adr_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [1:0]  m0_sel_i,
  input  logic [15:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic [15:0] m0_dat_o,
  input  logic [15:1] m1_adr_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  output logic [15:0] m1_dat_o,
  output logic [15:1] s_adr_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic [1:0]  s_sel_o,
  output logic [15:0] s_dat_o,
  input  logic [15:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);

  localparam logic [3:0] LP_MAX = 4'(BURST_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  state_t      w_pick_state;
  logic [3:0]  r_vcnt;
  logic        w_own0;
  logic        w_own1;
  logic        w_pick_v;
  logic        w_pick_c;
  logic        w_burst_done;
  logic        w_enter_own0;

  assign w_own0 = (r_state == ST_OWN0);
  assign w_own1 = (r_state == ST_OWN1);

  // Video wins unless the CPU is waiting and video has used up its burst.
  assign w_pick_v = m1_cyc_i & (~m0_cyc_i | (r_vcnt < LP_MAX));
  assign w_pick_c = ~w_pick_v & m0_cyc_i;

  always_comb begin
    w_pick_state = ST_IDLE;
    if (w_pick_v)
      w_pick_state = ST_OWN1;
    else if (w_pick_c)
      w_pick_state = ST_OWN0;
  end

  // True when the ack now in flight is the last video ack of this burst.
  assign w_burst_done = ({1'b0, r_vcnt} + 5'd1) >= {1'b0, LP_MAX};

  // State register
  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = w_pick_state;
      ST_OWN0: begin
        if (!m0_cyc_i)
          w_state_nxt = w_pick_state;
        else if (m0_ack_o && m1_cyc_i)
          w_state_nxt = ST_OWN1;
      end
      ST_OWN1: begin
        if (!m1_cyc_i)
          w_state_nxt = w_pick_state;
        else if (m1_ack_o && m0_cyc_i && w_burst_done)
          w_state_nxt = ST_OWN0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_enter_own0 = (w_state_nxt == ST_OWN0) && !w_own0;

  // Burst counter: clears take priority so the CPU grant always starts a fresh burst.
  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i)
      r_vcnt <= 4'd0;
    else if (!m0_cyc_i || w_enter_own0)
      r_vcnt <= 4'd0;
    else if (m1_ack_o && (r_vcnt != LP_MAX))
      r_vcnt <= r_vcnt + 4'd1;
  end

  // Output logic: bus mux driven from the registered owner
  always_comb begin
    s_adr_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_sel_o = 2'b00;
    s_dat_o = '0;
    case (r_state)
      ST_OWN0: begin
        s_adr_o = m0_adr_i;
        s_we_o  = m0_we_i;
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        s_sel_o = m0_sel_i;
        s_dat_o = m0_dat_i;
      end
      ST_OWN1: begin
        s_adr_o = m1_adr_i;
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        s_sel_o = 2'b11;
      end
      default: ;
    endcase
  end

  assign m0_ack_o = s_ack_i & w_own0;
  assign m1_ack_o = s_ack_i & w_own1;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt_o    = {w_own1, w_own0};

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter

module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        res;
  logic [15:1] m0_adr;
  logic        m0_we, m0_cyc, m0_stb;
  logic [1:0]  m0_sel;
  logic [15:0] m0_dat_w;
  logic        m0_ack;
  logic [15:0] m0_dat_r;
  logic [15:1] m1_adr;
  logic        m1_cyc, m1_stb;
  logic        m1_ack;
  logic [15:0] m1_dat_r;
  logic [15:1] s_adr;
  logic        s_we, s_cyc, s_stb;
  logic [1:0]  s_sel;
  logic [15:0] s_dat_w;
  logic [15:0] s_dat_r;
  logic        s_ack;
  logic [1:0]  gnt;

  int n_vec = 0;
  int n_err = 0;
  int m1_ack_seen = 0;

  ram_arbiter #(.BURST_MAX(4)) dut (
    .clk_i(clk), .res_i(res),
    .m0_adr_i(m0_adr), .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
    .m0_sel_i(m0_sel), .m0_dat_i(m0_dat_w), .m0_ack_o(m0_ack), .m0_dat_o(m0_dat_r),
    .m1_adr_i(m1_adr), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
    .m1_ack_o(m1_ack), .m1_dat_o(m1_dat_r),
    .s_adr_o(s_adr), .s_we_o(s_we), .s_cyc_o(s_cyc), .s_stb_o(s_stb),
    .s_sel_o(s_sel), .s_dat_o(s_dat_w), .s_dat_i(s_dat_r), .s_ack_i(s_ack),
    .gnt_o(gnt)
  );

  always #5 clk = ~clk;

  // RAM model: byte-lane memory with a registered read and an ack every second cycle.
  logic [15:0] mem [0:32767];
  always @(posedge clk or posedge res) begin
    if (res) begin
      s_ack <= 1'b0;
    end else begin
      s_ack   <= s_cyc & s_stb & ~s_ack;
      s_dat_r <= mem[s_adr];
      if (s_cyc && s_stb && s_we && !s_ack) begin
        if (s_sel[0]) mem[s_adr][7:0]  <= s_dat_w[7:0];
        if (s_sel[1]) mem[s_adr][15:8] <= s_dat_w[15:8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_xfer(input logic we, input logic [15:1] adr, input logic [1:0] sel,
                          input logic [15:0] dat, output logic [15:0] rd, output logic we_seen);
    bit done = 0;
    m0_adr = adr; m0_we = we; m0_sel = sel; m0_dat_w = dat;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    rd = '0; we_seen = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (m1_ack) m1_ack_seen++;
      if (i == 0) chk("grant_latency", {31'd0, s_cyc}, 32'd1);
      if (m0_ack) begin
        rd = m0_dat_r;
        we_seen = s_we;
        done = 1;
      end
    end
    if (!done) chk("cpu_ack_timeout", 32'd0, 32'd1);
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
    tick();
  endtask

  logic [15:0] rd;
  logic        wes;
  int          nack, idle_cnt, sat_err, cpu_wait_ack, v_acks;
  bit          first_v, done;

  initial begin
    res = 1'b1;
    m0_adr = '0; m0_we = 0; m0_cyc = 0; m0_stb = 0; m0_sel = 2'b00; m0_dat_w = '0;
    m1_adr = '0; m1_cyc = 0; m1_stb = 0;
    tick(); tick();
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_s_cyc", {31'd0, s_cyc}, 32'd0);
    chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("rst_vcnt", {28'd0, dut.r_vcnt}, 32'd0);
    res = 1'b0;
    tick();

    // CPU solo write / read-back, plus preload for byte-lane test
    cpu_xfer(1'b1, 15'h0020, 2'b11, 16'hAAAA, rd, wes);
    cpu_xfer(1'b1, 15'h0010, 2'b11, 16'hBEEF, rd, wes);
    chk("solo_we", {31'd0, wes}, 32'd1);
    cpu_xfer(1'b0, 15'h0010, 2'b11, 16'h0000, rd, wes);
    chk("solo_rd", {16'd0, rd}, 32'h0000BEEF);
    chk("solo_rd_we", {31'd0, wes}, 32'd0);

    // Byte lane 0 write
    cpu_xfer(1'b1, 15'h0020, 2'b01, 16'h0012, rd, wes);
    cpu_xfer(1'b0, 15'h0020, 2'b11, 16'h0000, rd, wes);
    chk("byte_lane", {16'd0, rd}, 32'h0000AA12);
    chk("solo_no_m1_ack", m1_ack_seen, 32'd0);

    // Sustained contention: v,v,v,v,c repeating
    m0_adr = 15'h0020; m0_we = 0; m0_sel = 2'b11; m0_cyc = 1; m0_stb = 1;
    m1_adr = 15'h0010; m1_cyc = 1; m1_stb = 1;
    nack = 0; idle_cnt = 0; sat_err = 0; first_v = 1;
    for (int i = 0; i < 200 && nack < 20; i++) begin
      tick();
      if (gnt == 2'b00) idle_cnt++;
      if (dut.r_vcnt > 4'd4) sat_err++;
      if (m0_ack && m1_ack) chk("both_acked", 32'd1, 32'd0);
      if (m0_ack || m1_ack) begin
        chk("ack_seq", {31'd0, m1_ack}, ((nack % 5) < 4) ? 32'd1 : 32'd0);
        if (m1_ack && first_v) begin
          chk("video_data", {16'd0, m1_dat_r}, 32'h0000BEEF);
          first_v = 0;
        end
        if (m0_ack) chk("cpu_data", {16'd0, m0_dat_r}, 32'h0000AA12);
        nack++;
      end
    end
    chk("cont_ack_count", nack, 32'd20);
    chk("cont_idle_cycles", idle_cnt, 32'd0);
    chk("cont_vcnt_sat", sat_err, 32'd0);
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    tick(); tick();
    chk("cont_end_idle", {30'd0, gnt}, 32'd0);

    // Asynchronous reset mid-transfer
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    tick(); tick(); tick();
    #2 res = 1'b1;
    #1;
    chk("arst_gnt", {30'd0, gnt}, 32'd0);
    chk("arst_s_cyc", {31'd0, s_cyc}, 32'd0);
    chk("arst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    #1 res = 1'b0;
    tick();
    chk("arst_regrant", {30'd0, gnt}, 32'd2);
    chk("arst_regrant_cyc", {31'd0, s_cyc}, 32'd1);
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    tick(); tick();

    // CPU preemption followed by release handoff
    m0_adr = 15'h0010; m0_we = 0; m0_cyc = 1; m0_stb = 1;
    tick();
    chk("pre_cpu_gnt", {30'd0, gnt}, 32'd1);
    m1_adr = 15'h0020; m1_cyc = 1; m1_stb = 1;
    tick();
    chk("pre_cpu_completes", {31'd0, m0_ack}, 32'd1);
    tick();
    chk("pre_video_gnt", {30'd0, gnt}, 32'd2);
    chk("pre_no_stray_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
    v_acks = 0; cpu_wait_ack = 0;
    for (int i = 0; i < 20 && v_acks < 2; i++) begin
      tick();
      if (m0_ack) cpu_wait_ack++;
      if (m1_ack) begin
        v_acks++;
        if (v_acks == 2) begin
          chk("pre_vcnt_mid", {28'd0, dut.r_vcnt}, 32'd1);
          m1_cyc = 0; m1_stb = 0;
        end
      end
    end
    chk("pre_video_acks", v_acks, 32'd2);
    chk("pre_cpu_unacked", cpu_wait_ack, 32'd0);
    tick();
    chk("rel_cpu_gnt", {30'd0, gnt}, 32'd1);
    chk("rel_vcnt_zero", {28'd0, dut.r_vcnt}, 32'd0);
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (m0_ack) begin
        done = 1;
        chk("rel_cpu_data", {16'd0, m0_dat_r}, 32'h0000BEEF);
      end
    end
    if (!done) chk("rel_cpu_ack_timeout", 32'd0, 32'd1);
    m0_cyc = 0; m0_stb = 0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-master Wishbone arbiter that shares the single system-RAM port (dual RAMB16_S9 byte lanes plus the single-cycle ACK generator) between the STEAMER16X4 CPU (master 0) and a read-only video fetch master (master 1). Video has priority for display refresh. A burst limit guarantees the CPU one RAM access in every `BURST_MAX+1` granted accesses under contention. The block sits between both masters and the RAM address decode. It forwards bus signals combinationally from the owning master and routes `s_ack_i` back to that master only.

## Interface
- `BURST_MAX`, default 4: maximum consecutive video acks while the CPU waits. Legal range is 1..15.
- `clk_i` in 1: system clock (50 MHz).
- `res_i` in 1: asynchronous, active-high reset.
- `m0_adr_i` in [15:1]: CPU word address.
- `m0_we_i` in 1: CPU write enable.
- `m0_cyc_i`, `m0_stb_i` in 1 each: CPU cycle and strobe.
- `m0_sel_i` in [1:0]: CPU byte lanes. Bit 0 is [7:0], bit 1 is [15:8].
- `m0_dat_i` in 16: CPU write data.
- `m0_ack_o` out 1: CPU acknowledge.
- `m0_dat_o` out 16: CPU read data.
- `m1_adr_i` in [15:1]: video word address.
- `m1_cyc_i`, `m1_stb_i` in 1 each: video cycle and strobe. Video never writes.
- `m1_ack_o` out 1: video acknowledge.
- `m1_dat_o` out 16: video read data.
- `s_adr_o` out [15:1], `s_we_o` out 1, `s_cyc_o` out 1, `s_stb_o` out 1, `s_sel_o` out [1:0], `s_dat_o` out 16: RAM-side request.
- `s_dat_i` in 16, `s_ack_i` in 1: RAM-side response.
- `gnt_o` out [1:0]: current owner, one-hot. Bit 0 is CPU, bit 1 is video, 00 is idle.

## Operation
- State register: IDLE, OWN0, OWN1. Burst counter `vcnt` is 4 bits and saturates at `BURST_MAX`.
- Muxing is combinational on the registered state:
  - OWN0: `s_*` = m0 signals.
  - OWN1: `s_adr_o` = `m1_adr_i`, `s_we_o` = 0, `s_sel_o` = 11, `s_dat_o` = 0, `s_cyc_o` = `m1_cyc_i`, `s_stb_o` = `m1_stb_i`.
  - IDLE: all `s_*` = 0.
- `m0_ack_o` = `s_ack_i` & OWN0. `m1_ack_o` = `s_ack_i` & OWN1.
- `m0_dat_o` = `m1_dat_o` = `s_dat_i`, broadcast. Only the acked master samples it.
- Arbitration decision `pick`:
  - `pick` = 1 if `m1_cyc_i` & (`!m0_cyc_i` | `vcnt` < `BURST_MAX`).
  - Otherwise `pick` = 0 if `m0_cyc_i`.
  - Otherwise `pick` = none.
- IDLE: go to OWN`pick`, or stay IDLE if `pick` is none.
- OWN0:
  - `!m0_cyc_i`: re-arbitrate via `pick`. Handoff costs no idle cycle.
  - `m0_ack_o` & `m1_cyc_i`: go to OWN1. Video preempts the CPU at each ack boundary.
  - Otherwise hold.
- OWN1:
  - `!m1_cyc_i`: re-arbitrate.
  - `m1_ack_o` & `m0_cyc_i` & (`vcnt`+1 >= `BURST_MAX`): go to OWN0.
  - Otherwise hold.
- `vcnt`:
  - +1 (saturating) on each `m1_ack_o` while `m0_cyc_i` = 1.
  - Cleared on entry to OWN0.
  - Cleared whenever `m0_cyc_i` = 0.
- A preempted master keeps `cyc`/`stb` asserted and simply sees no ack until it is re-granted. Its transfer is never lost or duplicated.

## Timing
- Reset (async, immediate): state = IDLE, `vcnt` = 0. Consequently `gnt_o` = 00, every `s_*` = 0, and both acks = 0. Reset mid-transfer drops ownership at once. The ACK generator clears on the same reset.
- Arbitration latency: a request seen in IDLE drives `s_cyc_o` in the next cycle.
- With the RAM ACK generator (ack every second cycle), a solo master gets one word per 2 cycles after a 1-cycle grant.
- Handoff at an ack boundary: the new owner's strobe reaches RAM the cycle after the ack edge. The ACK generator is low that cycle (`~ack`), so no stray ack is forwarded.
- Simultaneous request in IDLE with `vcnt` = 0: video wins.
- Under sustained contention the grant pattern is exactly `BURST_MAX` video acks, then 1 CPU ack, repeating.
- `vcnt` never exceeds `BURST_MAX`. No wrap-around.
- Ack and data paths are purely combinational from `s_ack_i`/`s_dat_i`. The only registers are the state and `vcnt`.

## Test plan
- Reset: assert `res_i` asynchronously between clock edges with both masters requesting. Required: `gnt_o` = 00, `s_cyc_o` = 0, both acks = 0 immediately. After release, the video request is granted 1 cycle later.
- CPU solo: write 0xBEEF to word 0x0010 with sel = 11, then read it back. Required: `s_we_o` = 1 on the write, `m0_dat_o` = 0xBEEF on the read ack, `m1_ack_o` never asserted.
- Byte lane: CPU writes 0x12 with sel = 01 to word 0x0020, which held 0xAAAA. Required: read back 0xAA12.
- Contention with `BURST_MAX` = 4: both masters hold cyc/stb for 20 acks. Required: ack sequence v,v,v,v,c,v,v,v,v,c,… and `gnt_o` toggles with no idle cycle between owners.
- CPU preemption: CPU owns the bus and video raises cyc mid-transfer. Required: the CPU completes its current ack, then `gnt_o` = 10 on the next cycle, and the CPU's pending strobe is unacked until re-granted.
- Release handoff: video drops cyc while the CPU is waiting. Required: `gnt_o` = 01 the next cycle, and `vcnt` reads 0 after the grant.
